// File: rtl/contador_163_mod.sv
// Modulo-N up/down counter with 74163-style clear/load/enable controls, wrap or saturate ends,
// a combinational rco and a registered wrap pulse. Optional prescaler: define CONTADOR_PRESCALER_EN.
module contador_163_mod #(
    parameter int WIDTH    = 16,
    parameter int MODULO   = 2001,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ld,
    input  logic             ent,
    input  logic             enp,
    input  logic             up,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             wrap
);

    // Terminal value; with MODULO == 2**WIDTH this is all ones and overflow wraps naturally.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);

    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
        $error("contador_163_mod: MODULO out of range");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("contador_163_mod: PRESCALE must be >= 2");
    end

    logic             at_top;
    logic             at_bot;
    logic             step;
    logic             wrap_next;
    logic [WIDTH-1:0] q_next;

    assign at_top = (Q == TOP);
    assign at_bot = (Q == '0);
    assign rco    = ent && (up ? at_top : at_bot);

`ifdef CONTADOR_PRESCALER_EN
    localparam int            PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p;

    always_ff @(posedge clock) begin
        if (!clr || !ld)
            p <= '0;
        else if (ent && enp)
            p <= (p == P_LAST) ? '0 : p + 1'b1;
    end

    assign step = ent && enp && (p == P_LAST);
`else
    assign step = ent && enp;
`endif

    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (step) begin
            if (up) begin
                if (!at_top) begin
                    q_next = Q + 1'b1;
                end else if (SATURATE == 0) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    q_next = Q - 1'b1;
                end else if (SATURATE == 0) begin
                    q_next    = TOP;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    // Power-up state is established by the first clr cycle.
    always_ff @(posedge clock) begin
        if (!clr) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (!ld) begin
            Q    <= (D > TOP) ? TOP : D;
            wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule
